// File: rtl/lagarto_pmu_counters.sv
// -----------------------------------------------------------------------------
// lagarto_pmu_counters
//
// Programmable performance-counter bank for the Lagarto tile. Each of the
// NUM_CNT counters selects one bit of the registered PMU event vector and
// increments on every cycle that bit is high while CTRL.EN is set. Software
// accesses the bank through a valid/ready request port with a one-entry
// response buffer. A level interrupt is raised when an enabled counter
// overflows.
//
// Ports:
//   clk_i          clock
//   reset_l        asynchronous active-low reset
//   pmu_sig_i      per-cycle event pulses (bit 0 is the cycle event)
//   req_valid_i    request valid
//   req_ready_o    request accepted when valid & ready
//   req_we_i       1 = write, 0 = read
//   req_addr_i     register word address
//   req_wdata_i    write data
//   rsp_valid_o    response valid, held until rsp_ready_i
//   rsp_ready_i    response consumed when valid & ready
//   rsp_rdata_o    read data (0 for writes)
//   rsp_err_o      access hit an unmapped address
//   overflow_irq_o level interrupt: |(OVF_STATUS & OVF_IRQ_EN)
//
// Register map (word addresses):
//   0x00 CTRL        bit0 EN, bit1 CLR (self-clearing), bit2 FREEZE
//   0x01 OVF_STATUS  per-counter overflow flags, write-1-to-clear
//   0x02 OVF_IRQ_EN  per-counter interrupt enables
//   0x08+i EVSEL[i]  5-bit event select
//   0x10+i CNT[i]    counter value
// -----------------------------------------------------------------------------
module lagarto_pmu_counters #(
    parameter int NUM_EVENTS = 25,
    parameter int NUM_CNT    = 8,
    parameter int CNT_W      = 64,
    parameter int ADDR_W     = 6
) (
    input  logic                  clk_i,
    input  logic                  reset_l,
    input  logic [NUM_EVENTS-1:0] pmu_sig_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [ADDR_W-1:0]     req_addr_i,
    input  logic [63:0]           req_wdata_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [63:0]           rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  overflow_irq_o
);

    localparam int SEL_W = 5;

    // Global state
    logic [NUM_EVENTS-1:0] sig_reg;
    logic                  ctrl_en_reg, ctrl_en_next;
    logic                  ctrl_frz_reg, ctrl_frz_next;
    logic [NUM_CNT-1:0]    ovf_status_reg, ovf_status_next;
    logic [NUM_CNT-1:0]    ovf_irq_en_reg;
    logic                  rsp_valid_reg;
    logic [63:0]           rsp_rdata_reg;
    logic                  rsp_err_reg;

    // Per-counter views
    logic [CNT_W-1:0]      cnt_val   [NUM_CNT];
    logic [SEL_W-1:0]      evsel_val [NUM_CNT];
    logic [NUM_CNT-1:0]    ovf_set;
    logic [NUM_CNT-1:0]    hit_evsel;
    logic [NUM_CNT-1:0]    hit_cnt;

    // Request decode
    logic req_fire, wr_fire;
    logic hit_ctrl, hit_ovf, hit_irqen, mapped;
    logic clr_req;
    logic [63:0] rd_data;

    assign req_ready_o = !rsp_valid_reg || rsp_ready_i;
    assign req_fire    = req_valid_i && req_ready_o;
    assign wr_fire     = req_fire && req_we_i;

    assign hit_ctrl  = (req_addr_i == ADDR_W'(0));
    assign hit_ovf   = (req_addr_i == ADDR_W'(1));
    assign hit_irqen = (req_addr_i == ADDR_W'(2));
    assign mapped    = hit_ctrl || hit_ovf || hit_irqen || (|hit_evsel) || (|hit_cnt);

    // CLR overrides every counter update on the accept edge.
    assign clr_req = wr_fire && hit_ctrl && req_wdata_i[1];

    generate
        for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_reg, cnt_next;
            logic [SEL_W-1:0] evsel_reg;
            logic             sel_bit;
            logic             inc;
            logic             cnt_wr;

            assign hit_evsel[gi] = (req_addr_i == ADDR_W'(8 + gi));
            assign hit_cnt[gi]   = (req_addr_i == ADDR_W'(16 + gi));
            assign cnt_wr        = wr_fire && hit_cnt[gi];

            // Selects beyond the event vector never match, so they never count.
            always_comb begin
                sel_bit = 1'b0;
                for (int e = 0; e < NUM_EVENTS; e++) begin
                    if (evsel_reg == SEL_W'(e)) sel_bit = sig_reg[e];
                end
            end

            assign inc = ctrl_en_reg && sel_bit;

            // Overflow only when the increment really takes effect.
            assign ovf_set[gi] = inc && (&cnt_reg) && !clr_req && !cnt_wr;

            always_comb begin
                cnt_next = cnt_reg;
                if (clr_req)     cnt_next = '0;
                else if (cnt_wr) cnt_next = req_wdata_i[CNT_W-1:0];
                else if (inc)    cnt_next = cnt_reg + CNT_W'(1);
            end

            always_ff @(posedge clk_i or negedge reset_l) begin
                if (!reset_l) begin
                    cnt_reg   <= '0;
                    evsel_reg <= SEL_W'(gi);
                end else begin
                    cnt_reg <= cnt_next;
                    if (wr_fire && hit_evsel[gi]) evsel_reg <= req_wdata_i[SEL_W-1:0];
                end
            end

            assign cnt_val[gi]   = cnt_reg;
            assign evsel_val[gi] = evsel_reg;
        end
    endgenerate

    // Read mux over pre-edge register state.
    always_comb begin
        rd_data = '0;
        if (hit_ctrl)  rd_data = {61'd0, ctrl_frz_reg, 1'b0, ctrl_en_reg};
        if (hit_ovf)   rd_data = 64'(ovf_status_reg);
        if (hit_irqen) rd_data = 64'(ovf_irq_en_reg);
        for (int i = 0; i < NUM_CNT; i++) begin
            if (hit_evsel[i]) rd_data = 64'(evsel_val[i]);
            if (hit_cnt[i])   rd_data = 64'(cnt_val[i]);
        end
    end

    // CTRL and overflow status next-state. A fresh overflow beats a W1C on
    // the same edge; FREEZE drops EN as soon as any counter wraps.
    always_comb begin
        ctrl_en_next  = ctrl_en_reg;
        ctrl_frz_next = ctrl_frz_reg;
        if (wr_fire && hit_ctrl) begin
            ctrl_en_next  = req_wdata_i[0];
            ctrl_frz_next = req_wdata_i[2];
        end
        if (ctrl_frz_reg && (|ovf_set)) ctrl_en_next = 1'b0;

        ovf_status_next = ovf_status_reg;
        if (wr_fire && hit_ovf) ovf_status_next = ovf_status_reg & ~req_wdata_i[NUM_CNT-1:0];
        ovf_status_next = ovf_status_next | ovf_set;
    end

    always_ff @(posedge clk_i or negedge reset_l) begin
        if (!reset_l) begin
            sig_reg        <= '0;
            ctrl_en_reg    <= 1'b0;
            ctrl_frz_reg   <= 1'b0;
            ovf_status_reg <= '0;
            ovf_irq_en_reg <= '0;
            rsp_valid_reg  <= 1'b0;
            rsp_rdata_reg  <= '0;
            rsp_err_reg    <= 1'b0;
        end else begin
            sig_reg        <= pmu_sig_i;
            ctrl_en_reg    <= ctrl_en_next;
            ctrl_frz_reg   <= ctrl_frz_next;
            ovf_status_reg <= ovf_status_next;
            if (wr_fire && hit_irqen) ovf_irq_en_reg <= req_wdata_i[NUM_CNT-1:0];

            if (req_fire) begin
                rsp_valid_reg <= 1'b1;
                rsp_rdata_reg <= req_we_i ? 64'd0 : rd_data;
                rsp_err_reg   <= !mapped;
            end else if (rsp_ready_i) begin
                rsp_valid_reg <= 1'b0;
            end
        end
    end

    assign rsp_valid_o    = rsp_valid_reg;
    assign rsp_rdata_o    = rsp_rdata_reg;
    assign rsp_err_o      = rsp_err_reg;
    assign overflow_irq_o = |(ovf_status_reg & ovf_irq_en_reg);

endmodule

// File: tb/tb_lagarto_pmu_counters.sv
module tb_lagarto_pmu_counters;

    logic        clk_i = 1'b0;
    logic        reset_l;
    logic [24:0] pmu_sig_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [5:0]  req_addr_i;
    logic [63:0] req_wdata_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [63:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        overflow_irq_o;

    int test_cnt = 0;
    int fail_cnt = 0;

    logic [63:0] exp_data_q[$];
    bit          exp_err_q[$];
    logic [5:0]  exp_addr_q[$];

    lagarto_pmu_counters dut (
        .clk_i          (clk_i),
        .reset_l        (reset_l),
        .pmu_sig_i      (pmu_sig_i),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_we_i       (req_we_i),
        .req_addr_i     (req_addr_i),
        .req_wdata_i    (req_wdata_i),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_ready_i    (rsp_ready_i),
        .rsp_rdata_o    (rsp_rdata_o),
        .rsp_err_o      (rsp_err_o),
        .overflow_irq_o (overflow_irq_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        test_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: one response per cycle it is consumed.
    always @(negedge clk_i) begin
        if (reset_l === 1'b1 && rsp_valid_o === 1'b1 && rsp_ready_i === 1'b1) begin
            if (exp_data_q.size() == 0) begin
                test_cnt++;
                fail_cnt++;
                $display("FAIL unexpected_rsp: got data 0x%0h err %0b expected no response",
                         rsp_rdata_o, rsp_err_o);
            end else begin
                logic [63:0] d;
                bit          e;
                logic [5:0]  a;
                d = exp_data_q.pop_front();
                e = exp_err_q.pop_front();
                a = exp_addr_q.pop_front();
                $display("[TB] rsp addr 0x%02h data 0x%0h err %0b (exp 0x%0h err %0b)",
                         a, rsp_rdata_o, rsp_err_o, d, e);
                check($sformatf("rsp_data@0x%02h", a), rsp_rdata_o, d);
                check($sformatf("rsp_err@0x%02h", a), 64'(rsp_err_o), 64'(e));
            end
        end
    end

    // Call at posedge+1; returns at accept edge +1.
    task automatic do_req(input bit we, input logic [5:0] addr, input logic [63:0] wd,
                          input logic [63:0] exp_d, input bit exp_e);
        int n;
        bit acc;
        exp_data_q.push_back(we ? 64'd0 : exp_d);
        exp_err_q.push_back(exp_e);
        exp_addr_q.push_back(addr);
        req_valid_i = 1'b1;
        req_we_i    = we;
        req_addr_i  = addr;
        req_wdata_i = wd;
        n   = 0;
        acc = 1'b0;
        while (!acc && n < 50) begin
            @(negedge clk_i);
            acc = req_ready_o;
            @(posedge clk_i);
            n++;
        end
        #1;
        req_valid_i = 1'b0;
        req_we_i    = 1'b0;
        if (!acc) begin
            test_cnt++;
            fail_cnt++;
            $display("FAIL req_timeout@0x%02h: got no accept in 50 cycles expected accept", addr);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic drive_sig(input logic [24:0] v, input int n);
        pmu_sig_i = v;
        idle(n);
        pmu_sig_i = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_l     = 1'b0;
        pmu_sig_i   = '0;
        req_valid_i = 1'b0;
        req_we_i    = 1'b0;
        req_addr_i  = '0;
        req_wdata_i = '0;
        rsp_ready_i = 1'b1;
        #1;
        check("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
        check("rst_rsp_rdata", rsp_rdata_o, 64'd0);
        check("rst_rsp_err", 64'(rsp_err_o), 64'd0);
        check("rst_req_ready", 64'(req_ready_o), 64'd1);
        check("rst_irq", 64'(overflow_irq_o), 64'd0);
        repeat (3) @(posedge clk_i);
        #3 reset_l = 1'b1;
        @(posedge clk_i);
        #1;

        // Reset values through the register port.
        for (int i = 0; i < 8; i++) do_req(1'b0, 6'(8 + i), 64'd0, 64'(i), 1'b0);
        do_req(1'b0, 6'h00, 64'd0, 64'd0, 1'b0);
        do_req(1'b0, 6'h01, 64'd0, 64'd0, 1'b0);
        do_req(1'b0, 6'h02, 64'd0, 64'd0, 1'b0);
        for (int i = 0; i < 8; i++) do_req(1'b0, 6'(16 + i), 64'd0, 64'd0, 1'b0);
        do_req(1'b0, 6'h3F, 64'd0, 64'd0, 1'b1);
        do_req(1'b0, 6'h03, 64'd0, 64'd0, 1'b1);
        do_req(1'b0, 6'h18, 64'd0, 64'd0, 1'b1);
        do_req(1'b1, 6'h20, 64'hDEAD, 64'd0, 1'b1);

        // EVSEL: shared event and out-of-range select.
        do_req(1'b1, 6'h0C, 64'd3, 64'd0, 1'b0);
        do_req(1'b1, 6'h0D, 64'hFF, 64'd0, 1'b0);
        do_req(1'b0, 6'h0D, 64'd0, 64'h1F, 1'b0);

        // Basic counting: 20 cycle events, 5 pulses of event 3.
        do_req(1'b1, 6'h00, 64'h1, 64'd0, 1'b0);
        idle(2);
        for (int k = 0; k < 20; k++) begin
            pmu_sig_i = '0;
            pmu_sig_i[0] = 1'b1;
            pmu_sig_i[3] = (k >= 5 && k < 10);
            idle(1);
        end
        pmu_sig_i = '0;
        idle(3);
        do_req(1'b1, 6'h00, 64'h0, 64'd0, 1'b0);
        do_req(1'b0, 6'h10, 64'd0, 64'd20, 1'b0);
        do_req(1'b0, 6'h13, 64'd0, 64'd5, 1'b0);
        do_req(1'b0, 6'h14, 64'd0, 64'd5, 1'b0);
        do_req(1'b0, 6'h11, 64'd0, 64'd0, 1'b0);
        do_req(1'b0, 6'h12, 64'd0, 64'd0, 1'b0);
        do_req(1'b0, 6'h15, 64'd0, 64'd0, 1'b0);

        // Overflow with FREEZE and interrupt.
        do_req(1'b1, 6'h12, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0, 1'b0);
        do_req(1'b1, 6'h0A, 64'd0, 64'd0, 1'b0);
        do_req(1'b1, 6'h02, 64'h04, 64'd0, 1'b0);
        do_req(1'b1, 6'h00, 64'h5, 64'd0, 1'b0);
        idle(2);
        drive_sig(25'h1, 2);
        idle(3);
        check("irq_after_ovf", 64'(overflow_irq_o), 64'd1);
        do_req(1'b0, 6'h12, 64'd0, 64'd0, 1'b0);
        do_req(1'b0, 6'h01, 64'd0, 64'h04, 1'b0);
        do_req(1'b0, 6'h00, 64'd0, 64'h04, 1'b0);
        do_req(1'b0, 6'h10, 64'd0, 64'd22, 1'b0);
        do_req(1'b1, 6'h01, 64'h04, 64'd0, 1'b0);
        idle(2);
        check("irq_after_w1c", 64'(overflow_irq_o), 64'd0);
        do_req(1'b0, 6'h01, 64'd0, 64'd0, 1'b0);

        // Register write beats a coinciding increment.
        do_req(1'b1, 6'h00, 64'h1, 64'd0, 1'b0);
        idle(2);
        pmu_sig_i = 25'h2;
        idle(1);
        pmu_sig_i = '0;
        do_req(1'b1, 6'h11, 64'h10, 64'd0, 1'b0);
        idle(2);
        do_req(1'b0, 6'h11, 64'd0, 64'h10, 1'b0);
        drive_sig(25'h2, 1);
        idle(3);
        do_req(1'b0, 6'h11, 64'd0, 64'h11, 1'b0);

        // CLR while counting; the event sampled on the CLR edge counts next.
        pmu_sig_i = 25'h1;
        idle(3);
        do_req(1'b1, 6'h00, 64'h3, 64'd0, 1'b0);
        pmu_sig_i = '0;
        idle(3);
        do_req(1'b0, 6'h10, 64'd0, 64'd1, 1'b0);
        do_req(1'b0, 6'h12, 64'd0, 64'd1, 1'b0);
        do_req(1'b0, 6'h13, 64'd0, 64'd0, 1'b0);
        do_req(1'b0, 6'h11, 64'd0, 64'd0, 1'b0);
        do_req(1'b0, 6'h00, 64'd0, 64'h1, 1'b0);
        drive_sig(25'h1, 3);
        idle(3);
        do_req(1'b0, 6'h10, 64'd0, 64'd4, 1'b0);

        // Back-pressure: second request stalls, first response held.
        idle(2);
        rsp_ready_i = 1'b0;
        do_req(1'b0, 6'h10, 64'd0, 64'd4, 1'b0);
        fork
            do_req(1'b0, 6'h0D, 64'd0, 64'h1F, 1'b0);
            begin
                repeat (3) @(negedge clk_i);
                check("stall_req_ready", 64'(req_ready_o), 64'd0);
                check("stall_rsp_valid", 64'(rsp_valid_o), 64'd1);
                check("stall_rsp_held", rsp_rdata_o, 64'd4);
                @(posedge clk_i);
                #1 rsp_ready_i = 1'b1;
                @(negedge clk_i);
                @(negedge clk_i);
                check("b2b_second_valid", 64'(rsp_valid_o), 64'd1);
            end
        join
        idle(3);

        // Reset with a pending response.
        rsp_ready_i = 1'b0;
        do_req(1'b0, 6'h00, 64'd0, 64'h1, 1'b0);
        #2 reset_l = 1'b0;
        #1;
        check("rst_drops_rsp_valid", 64'(rsp_valid_o), 64'd0);
        void'(exp_data_q.pop_back());
        void'(exp_err_q.pop_back());
        void'(exp_addr_q.pop_back());
        #4 reset_l = 1'b1;
        rsp_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        do_req(1'b0, 6'h10, 64'd0, 64'd0, 1'b0);
        do_req(1'b0, 6'h00, 64'd0, 64'd0, 1'b0);
        idle(5);
        check("scoreboard_empty", 64'(exp_data_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule
